// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
//
// Register scoreboard that sits between decode (D) and write-back (W).
// Every architectural register except x0 has two saturating pending-writer
// counters:
//   pcnt : all in-flight writers of the register
//   lcnt : the subset of those writers that are long-latency (load, mul/div)
//
// A D-stage source that has a long-latency writer in flight stalls decode.
// A destination whose pcnt is already at its maximum also stalls, because
// one more writer could not be counted. Short-latency writers never stall a
// reader; they are expected to be covered by the bypass network.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   issue_valid/_wen/_long/_rd       instruction leaving D and its destination
//   rs1D, rs2D                       D-stage source register indices
//   wb_valid/_long/_rd               writer retiring in W
//   squash_valid/_long/_rd           in-flight writer killed by a flush
//   stall                            D must hold, issue refused
//   issue_ack                        issue accepted this cycle
//   busy_vec                         bit i set while register i has a writer
//   err                              sticky counter overflow/underflow
// -----------------------------------------------------------------------------

`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module wb_scoreboard #(
    parameter int NREG = 32,
    parameter int CW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    issue_valid,
    input  logic                    issue_wen,
    input  logic                    issue_long,
    input  logic [`RFIDX_WIDTH-1:0] issue_rd,
    input  logic [`RFIDX_WIDTH-1:0] rs1D,
    input  logic [`RFIDX_WIDTH-1:0] rs2D,

    input  logic                    wb_valid,
    input  logic                    wb_long,
    input  logic [`RFIDX_WIDTH-1:0] wb_rd,

    input  logic                    squash_valid,
    input  logic                    squash_long,
    input  logic [`RFIDX_WIDTH-1:0] squash_rd,

    output logic                    stall,
    output logic                    issue_ack,
    output logic [NREG-1:0]         busy_vec,
    output logic                    err
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] pcnt_q [NREG];
    logic [CW-1:0] pcnt_d [NREG];
    logic [CW-1:0] lcnt_q [NREG];
    logic [CW-1:0] lcnt_d [NREG];
    logic          err_q;
    logic          err_d;

    // Per-register one-hot event strobes. Bit 0 may be set by an x0 event
    // but is never consumed, which is how x0 stays untracked.
    logic [NREG-1:0] iss_hit;
    logic [NREG-1:0] iss_long_hit;
    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] wb_long_hit;
    logic [NREG-1:0] sq_hit;
    logic [NREG-1:0] sq_long_hit;

    logic rs1_hazard;
    logic rs2_hazard;
    logic rd_full;

    logic [CW:0] p_res;
    logic [CW:0] l_res;

    // Returns {error, new_value}. The sum is formed two bits wider than the
    // counter: the top bit flags a negative result, bit CW a result above
    // CNT_MAX (the largest reachable sum is CNT_MAX+1 and the smallest -2).
    function automatic logic [CW:0] sat_update(
        input logic [CW-1:0] cur,
        input logic          inc,
        input logic          dec_a,
        input logic          dec_b
    );
        logic [CW+1:0] sum;
        sum = {2'b00, cur}
            + {{(CW+1){1'b0}}, inc}
            - {{(CW+1){1'b0}}, dec_a}
            - {{(CW+1){1'b0}}, dec_b};
        if (sum[CW+1]) begin
            return {1'b1, {CW{1'b0}}};
        end else if (sum[CW]) begin
            return {1'b1, CNT_MAX};
        end else begin
            return {1'b0, sum[CW-1:0]};
        end
    endfunction

    // Hazard detection looks at registered counters only, so a write-back in
    // the same cycle does not release the stall; that costs one bubble but
    // keeps W off the decode timing path.
    always_comb begin
        rs1_hazard = (rs1D != '0) && (lcnt_q[rs1D] != '0);
        rs2_hazard = (rs2D != '0) && (lcnt_q[rs2D] != '0);
        rd_full    = issue_wen && (issue_rd != '0) && (pcnt_q[issue_rd] == CNT_MAX);
    end

    assign stall     = rs1_hazard || rs2_hazard || rd_full;
    assign issue_ack = issue_valid && !stall;

    always_comb begin
        iss_hit      = '0;
        iss_long_hit = '0;
        wb_hit       = '0;
        wb_long_hit  = '0;
        sq_hit       = '0;
        sq_long_hit  = '0;
        if (issue_ack && issue_wen) begin
            iss_hit[issue_rd]      = 1'b1;
            iss_long_hit[issue_rd] = issue_long;
        end
        if (wb_valid) begin
            wb_hit[wb_rd]      = 1'b1;
            wb_long_hit[wb_rd] = wb_long;
        end
        if (squash_valid) begin
            sq_hit[squash_rd]      = 1'b1;
            sq_long_hit[squash_rd] = squash_long;
        end
    end

    // All events on one register are folded into a single net update so a
    // same-cycle issue and retire to the same register cancel cleanly.
    always_comb begin
        pcnt_d = pcnt_q;
        lcnt_d = lcnt_q;
        err_d  = err_q;
        p_res  = '0;
        l_res  = '0;
        pcnt_d[0] = '0;
        lcnt_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            p_res     = sat_update(pcnt_q[i], iss_hit[i], wb_hit[i], sq_hit[i]);
            l_res     = sat_update(lcnt_q[i], iss_long_hit[i], wb_long_hit[i], sq_long_hit[i]);
            pcnt_d[i] = p_res[CW-1:0];
            lcnt_d[i] = l_res[CW-1:0];
            if (p_res[CW] || l_res[CW]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                pcnt_q[i] <= '0;
                lcnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            lcnt_q <= lcnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_vec[i] = (pcnt_q[i] != '0);
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module tb_wb_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_wen, issue_long;
    logic [4:0]  issue_rd, rs1D, rs2D;
    logic        wb_valid, wb_long;
    logic [4:0]  wb_rd;
    logic        squash_valid, squash_long;
    logic [4:0]  squash_rd;
    logic        stall, issue_ack, err;
    logic [31:0] busy_vec;

    int errors = 0;
    int checks = 0;

    // reference model: pending writers and long pending writers per register
    int pc [32];
    int lc [32];
    bit merr;

    wb_scoreboard #(.NREG(32), .CW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_long(issue_long),
        .issue_rd(issue_rd), .rs1D(rs1D), .rs2D(rs2D),
        .wb_valid(wb_valid), .wb_long(wb_long), .wb_rd(wb_rd),
        .squash_valid(squash_valid), .squash_long(squash_long), .squash_rd(squash_rd),
        .stall(stall), .issue_ack(issue_ack), .busy_vec(busy_vec), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic wen, input logic lng, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic wv, input logic wl, input logic [4:0] wr,
                         input logic sv, input logic sl, input logic [4:0] sr);
        issue_valid = iv; issue_wen = wen; issue_long = lng; issue_rd = rd;
        rs1D = r1; rs2D = r2;
        wb_valid = wv; wb_long = wl; wb_rd = wr;
        squash_valid = sv; squash_long = sl; squash_rd = sr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            pc[i] = 0;
            lc[i] = 0;
        end
        merr = 0;
    endtask

    function automatic bit m_stall();
        bit s;
        s = 0;
        if (rs1D != 0 && lc[rs1D] > 0) s = 1;
        if (rs2D != 0 && lc[rs2D] > 0) s = 1;
        if (issue_wen && issue_rd != 0 && pc[issue_rd] == MAXC) s = 1;
        return s;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) b[i] = (pc[i] > 0);
        return b;
    endfunction

    task automatic model_apply(input bit acc);
        int dp [32];
        int dl [32];
        int np, nl;
        for (int i = 0; i < 32; i++) begin
            dp[i] = 0;
            dl[i] = 0;
        end
        if (acc && issue_wen) begin
            dp[issue_rd] += 1;
            if (issue_long) dl[issue_rd] += 1;
        end
        if (wb_valid) begin
            dp[wb_rd] -= 1;
            if (wb_long) dl[wb_rd] -= 1;
        end
        if (squash_valid) begin
            dp[squash_rd] -= 1;
            if (squash_long) dl[squash_rd] -= 1;
        end
        for (int i = 1; i < 32; i++) begin
            np = pc[i] + dp[i];
            nl = lc[i] + dl[i];
            if (np > MAXC) begin np = MAXC; merr = 1; end
            if (np < 0)    begin np = 0;    merr = 1; end
            if (nl > MAXC) begin nl = MAXC; merr = 1; end
            if (nl < 0)    begin nl = 0;    merr = 1; end
            pc[i] = np;
            lc[i] = nl;
        end
    endtask

    // Called just after a rising edge with inputs already driven: checks the
    // combinational outputs against the model, then clocks and updates it.
    task automatic step();
        bit es;
        #1;
        es = m_stall();
        chk("stall", stall, es);
        chk("issue_ack", issue_ack, issue_valid && !es);
        chk("busy_vec", busy_vec, m_busy());
        chk("err", err, merr);
        @(posedge clk);
        model_apply(issue_valid && !es);
        #1;
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic reset_mid(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_busy"}, busy_vec, 32'h0);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_ack"}, issue_ack, issue_valid);
        model_clear();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        issue_valid = 1'b1;
        issue_wen   = 1'b1;
        issue_rd    = 5'd1;
        model_clear();
        #2;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ack", issue_ack, 1'b1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // long writer to x5 blocks a reader until the cycle after its retire
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("r5_stall", stall, 1'b1); chk("r5_busy", busy_vec[5], 1'b1);
        step();
        step();
        drive(0, 0, 0, 0, 5, 0, 1, 1, 5, 0, 0, 0);
        #1; chk("r5_stall_wb_cycle", stall, 1'b1);
        step();
        drive(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("r5_stall_clear", stall, 1'b0); chk("r5_idle", busy_vec[5], 1'b0);
        step();

        // short writer to x7 marks busy but never stalls a reader
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
        #1; chk("r7_no_stall", stall, 1'b0); chk("r7_busy", busy_vec[7], 1'b1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0); step();
        idle();
        #1; chk("r7_idle", busy_vec[7], 1'b0);
        step();

        // same-cycle issue and retire on x3 cancel
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 0, 3, 0, 0, 1, 0, 3, 0, 0, 0); step();
        idle();
        #1; chk("r3_still_busy", busy_vec[3], 1'b1); chk("r3_no_err", err, 1'b0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0); step();
        idle();
        #1; chk("r3_drained", busy_vec[3], 1'b0);
        step();

        // x9 fills to the counter maximum, fourth writer is refused
        repeat (3) begin
            drive(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0); step();
        end
        drive(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("r9_full_stall", stall, 1'b1); chk("r9_full_ack", issue_ack, 1'b0);
        step();
        drive(1, 1, 0, 9, 0, 0, 1, 0, 9, 0, 0, 0);
        #1; chk("r9_wb_cycle_ack", issue_ack, 1'b0);
        step();
        drive(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("r9_after_wb_ack", issue_ack, 1'b1);
        step();
        repeat (3) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0); step();
        end
        idle();
        #1; chk("r9_drained", busy_vec[9], 1'b0); chk("r9_no_err", err, 1'b0);
        step();

        // squash of a long writer to x12 behaves like its retire
        drive(1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("r12_stall", stall, 1'b1);
        step();
        drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 1, 1, 12); step();
        drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("r12_stall_clear", stall, 1'b0); chk("r12_idle", busy_vec[12], 1'b0);
        step();

        // underflow on x4 sets sticky err; writes to x0 are never tracked
        drive(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0);
        #1; chk("r4_err_before", err, 1'b0);
        step();
        idle();
        #1; chk("r4_err", err, 1'b1); chk("r4_busy", busy_vec[4], 1'b0);
        step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("x0_busy", busy_vec, 32'h0); chk("err_sticky", err, 1'b1);
        step();

        // reset in the middle of operation drops pending state
        drive(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 0, 2, 6, 0, 0, 0, 0, 0, 0, 0);
        reset_mid("mid_rst");
        drive(0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("post_rst_stall", stall, 1'b0);
        step();

        // randomized traffic on a small register window to force overlap
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)),
                  ($urandom_range(0, 9) < 1), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)));
            if (n % 75 == 74) begin
                issue_valid = 1'b1;
                reset_mid("rand_rst");
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32; number of architectural registers tracked.
REQ-002 SHALL have parameter CW, default 2; width of each per-register pending counter.
REQ-003 SHALL have port clk, input, 1; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset, asynchronous and active-low.
REQ-005 SHALL have port issue_valid, input, 1; an instruction requests to leave D this cycle.
REQ-006 SHALL have port issue_wen, input, 1; the issuing instruction writes rd.
REQ-007 SHALL have port issue_long, input, 1; the issuing instruction's result is long-latency (load, mul/div).
REQ-008 SHALL have port issue_rd, input, `RFIDX_WIDTH; destination of the issuing instruction.
REQ-009 SHALL have ports rs1D and rs2D, input, `RFIDX_WIDTH each; D-stage sources.
REQ-010 SHALL have ports wb_valid (input, 1), wb_long (input, 1) and wb_rd (input, `RFIDX_WIDTH); a write-back retires in W.
REQ-011 SHALL have ports squash_valid (input, 1), squash_long (input, 1) and squash_rd (input, `RFIDX_WIDTH); an in-flight writer is killed by flush.
REQ-012 SHALL have port stall, output, 1; D must hold and issue is refused.
REQ-013 SHALL have port issue_ack, output, 1; issue accepted this cycle.
REQ-014 SHALL have port busy_vec, output, NREG; bit i set when register i has any pending writer.
REQ-015 SHALL have port err, output, 1; sticky counter overflow/underflow flag.

Function
REQ-016 SHALL keep, per register i (1..NREG-1), two CW-bit counters: pcnt[i] counts all pending writers, lcnt[i] counts long-latency pending writers.
REQ-017 SHALL never track register 0: its counters are constant 0 and busy_vec[0] is 0.
REQ-018 SHALL drive stall=1 combinationally when any of these holds: (rs1D!=0 and lcnt[rs1D]>0); (rs2D!=0 and lcnt[rs2D]>0); (issue_wen and issue_rd!=0 and pcnt[issue_rd] at max 2^CW-1).
REQ-019 SHALL compute stall from registered counter state only; a same-cycle write-back does not clear stall (one-cycle bubble is accepted).
REQ-020 SHALL drive issue_ack = issue_valid and not stall.
REQ-021 SHALL, for an accepted issue with issue_wen=1 and issue_rd!=0, increment pcnt[issue_rd], and also lcnt[issue_rd] when issue_long=1.
REQ-022 SHALL, for wb_valid with wb_rd!=0, decrement pcnt[wb_rd], and also lcnt[wb_rd] when wb_long=1.
REQ-023 SHALL apply squash_valid with squash_rd!=0 exactly as a write-back (REQ-022, with squash_long selecting the lcnt decrement).
REQ-024 SHALL sum all same-cycle events on one register into a net delta (issue +1, wb -1, squash -1), applied in a single update.
REQ-025 SHALL saturate on net result: a result above max holds max and sets err; a result below 0 holds 0 and sets err.
REQ-026 SHALL ignore the counter updates of issue_valid when stall=1 (no increment, issue_ack=0, err unchanged).
REQ-027 SHALL drive busy_vec[i] = (pcnt[i]!=0), registered state only.
REQ-028 SHALL leave err set until reset once it is set.

Reset
REQ-029 SHALL, while rst_n=0, immediately clear all pcnt/lcnt and err, which makes busy_vec=0, stall=0 and issue_ack=issue_valid.
REQ-030 SHALL take an in-flight assertion of rst_n=0 mid-operation as discarding all pending state, with no recovery of the discarded entries.

Verification
REQ-031 SHALL cover: issue long rd=5, then next cycle rs1D=5 -> stall=1 until the cycle after wb_valid/wb_long for rd=5; busy_vec[5]=1 -> 0.
REQ-032 SHALL cover: issue short rd=7, then rs2D=7 -> stall=0 and busy_vec[7]=1; wb rd=7 -> busy_vec[7]=0 next cycle.
REQ-033 SHALL cover: same cycle, issue rd=3 and wb rd=3 with pcnt[3]=1 -> pcnt[3] remains 1 and err=0.
REQ-034 SHALL cover: three issues to rd=9 with no wb -> fourth issue_valid to rd=9 sees stall=1 and issue_ack=0; then one wb -> issue accepted.
REQ-035 SHALL cover: wb rd=4 with pcnt[4]=0 -> err=1, pcnt stays 0; also issue rd=0 -> busy_vec unchanged.
REQ-036 SHALL cover: long issue to rd=12, squash_valid/squash_long rd=12 -> lcnt and pcnt return to 0, stall clears; then assert rst_n low mid-operation -> all outputs at reset values within the same cycle.
